// File: rtl/mp_mon_pkg.sv
// Shared types and defaults for the multi-core run monitor.
// Used by mp_run_monitor, its interface, mp_top and the bench.
package mp_mon_pkg;

    typedef enum logic [1:0] {
        MON_IDLE,
        MON_RUN,
        MON_DONE,
        MON_TIMEOUT
    } mon_state_e;

    localparam int MP_N_CORES     = 3;
    localparam int MP_TIMEOUT_DEF = 400;

endpackage

// File: rtl/mp_run_monitor_if.sv
// Control/status bundle between the run monitor and its driver.
// master drives start, core levels and the stamp index; slave is the monitor.
interface mp_run_monitor_if
    import mp_mon_pkg::*;
#(
    parameter int N_CORES = MP_N_CORES,
    parameter int CNT_W   = 16
);
    localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic               start;
    logic [N_CORES-1:0] core_done;
    logic [N_CORES-1:0] core_pass;
    logic [IDX_W-1:0]   rd_idx;

    logic               busy;
    logic               run_done;
    logic               run_pass;
    logic               run_timeout;
    logic [N_CORES-1:0] done_mask;
    logic [N_CORES-1:0] fail_mask;
    logic [CNT_W-1:0]   total_cycles;
    logic               proto_err;
    logic [CNT_W-1:0]   rd_tstamp;

    modport master (
        output start, core_done, core_pass, rd_idx,
        input  busy, run_done, run_pass, run_timeout,
        input  done_mask, fail_mask, total_cycles,
        input  proto_err, rd_tstamp
    );

    modport slave (
        input  start, core_done, core_pass, rd_idx,
        output busy, run_done, run_pass, run_timeout,
        output done_mask, fail_mask, total_cycles,
        output proto_err, rd_tstamp
    );

endinterface

// File: rtl/mp_mon_core_latch.sv
// Per-core first-completion latch: done, pass verdict and finish stamp.
// Stamp storage exists only when MP_MON_TSTAMP_EN is defined.
module mp_mon_core_latch
`ifdef MP_MON_TSTAMP_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             done,
    input  logic             pass,
`ifdef MP_MON_TSTAMP_EN
    input  logic [CNT_W-1:0] cnt_nx,
    output logic [CNT_W-1:0] stamp,
`endif
    output logic             latched,
    output logic             fail,
    output logic             perr
);

    logic take;

    assign take = en && done && !latched;
    // a latched core must hold done high for the rest of the run
    assign perr = en && latched && !done;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            latched <= 1'b0;
            fail    <= 1'b0;
`ifdef MP_MON_TSTAMP_EN
            stamp   <= '0;
`endif
        end else if (take) begin
            latched <= 1'b1;
            fail    <= !pass;
`ifdef MP_MON_TSTAMP_EN
            stamp   <= cnt_nx;
`endif
        end
    end

endmodule

// File: rtl/mp_run_monitor.sv
// Run monitor: times a multi-core run and reduces done/pass levels to one verdict.
// Optional per-core finish timestamps under MP_MON_TSTAMP_EN.
module mp_run_monitor
    import mp_mon_pkg::*;
#(
    parameter int N_CORES        = MP_N_CORES,
    parameter int TIMEOUT_CYCLES = MP_TIMEOUT_DEF,
    parameter int CNT_W          = 16
)(
    input logic              clk,
    input logic              rst,
    mp_run_monitor_if.slave  bus
);

    if (((64'd1 << CNT_W) - 64'd1) < 64'(TIMEOUT_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    mon_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic [CNT_W-1:0]   total_cycles;
    logic               run_done;
    logic               run_pass;
    logic               run_timeout;
    logic               proto_err;
    logic [N_CORES-1:0] done_mask;
    logic [N_CORES-1:0] fail_mask;
    logic [N_CORES-1:0] new_fail;
    logic [N_CORES-1:0] perr_hit;
    logic               running;
    logic               clr;
    logic               complete;
    logic               at_limit;

    assign running  = (state == MON_RUN);
    assign clr      = bus.start && !running;
    assign cnt_nx   = cnt + CNT_W'(1);
    assign new_fail = bus.core_done & ~done_mask & ~bus.core_pass;
    assign complete = &(done_mask | bus.core_done);
    assign at_limit = (cnt_nx == LIMIT);

`ifdef MP_MON_TSTAMP_EN
    logic [CNT_W-1:0] stamp [N_CORES];
`endif

    for (genvar i = 0; i < N_CORES; i++) begin : g_core
`ifdef MP_MON_TSTAMP_EN
        mp_mon_core_latch #(.CNT_W(CNT_W)) u_latch (
`else
        mp_mon_core_latch u_latch (
`endif
            .clk     (clk),
            .rst     (rst),
            .clr     (clr),
            .en      (running),
            .done    (bus.core_done[i]),
            .pass    (bus.core_pass[i]),
`ifdef MP_MON_TSTAMP_EN
            .cnt_nx  (cnt_nx),
            .stamp   (stamp[i]),
`endif
            .latched (done_mask[i]),
            .fail    (fail_mask[i]),
            .perr    (perr_hit[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= MON_IDLE;
            cnt          <= '0;
            total_cycles <= '0;
            run_done     <= 1'b0;
            run_pass     <= 1'b0;
            run_timeout  <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            unique case (state)
                MON_IDLE, MON_DONE, MON_TIMEOUT: begin
                    if (bus.start) begin
                        state        <= MON_RUN;
                        cnt          <= '0;
                        total_cycles <= '0;
                        run_done     <= 1'b0;
                        run_pass     <= 1'b0;
                        run_timeout  <= 1'b0;
                        proto_err    <= 1'b0;
                    end
                end
                MON_RUN: begin
                    cnt <= cnt_nx;
                    if (|perr_hit) proto_err <= 1'b1;
                    // completion beats the limit on a shared edge
                    if (complete) begin
                        state        <= MON_DONE;
                        total_cycles <= cnt_nx;
                        run_done     <= 1'b1;
                        run_pass     <= ~|(fail_mask | new_fail);
                    end else if (at_limit) begin
                        state        <= MON_TIMEOUT;
                        total_cycles <= LIMIT;
                        run_timeout  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.busy         = running;
    assign bus.run_done     = run_done;
    assign bus.run_pass     = run_pass;
    assign bus.run_timeout  = run_timeout;
    assign bus.done_mask    = done_mask;
    assign bus.fail_mask    = fail_mask;
    assign bus.total_cycles = total_cycles;
    assign bus.proto_err    = proto_err;

`ifdef MP_MON_TSTAMP_EN
    always_comb begin
        bus.rd_tstamp = '0;
        if (int'(bus.rd_idx) < N_CORES) bus.rd_tstamp = stamp[bus.rd_idx];
    end
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^bus.rd_idx;
    assign bus.rd_tstamp = '0;
`endif

endmodule

// File: tb/tb_mp_run_monitor.sv
// Scoreboard bench for mp_run_monitor: per-run verdicts predicted from
// per-core finish cycles, checked by a monitor when busy falls.
module tb_mp_run_monitor;
    import mp_mon_pkg::*;

    localparam int N  = MP_N_CORES;
    localparam int T  = MP_TIMEOUT_DEF;
    localparam int CW = 16;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef struct packed {
        logic                 done;
        logic                 pass;
        logic                 tmo;
        logic                 perr;
        logic [N-1:0]         dmask;
        logic [N-1:0]         fmask;
        logic [CW-1:0]        total;
        logic [N-1:0][CW-1:0] stamp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mp_run_monitor_if #(.N_CORES(N), .CNT_W(CW)) bus ();

    mp_run_monitor #(
        .N_CORES        (N),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    bit   aborting = 1'b0;
    bit   ack = 1'b0;
    int   dcyc [N];
    int   drop [N];
    bit   pbit [N];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // run outcome from finish cycles alone: last finisher or the limit
    function automatic exp_t model();
        exp_t e;
        int   fin;
        bit   all;
        e   = '0;
        fin = 0;
        all = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (dcyc[i] == 0) all = 1'b0;
            else if (dcyc[i] > fin) fin = dcyc[i];
        end
        if (all && fin <= T) begin
            e.done  = 1'b1;
            e.total = CW'(fin);
        end else begin
            e.tmo   = 1'b1;
            e.total = CW'(T);
            fin     = T;
        end
        for (int i = 0; i < N; i++) begin
            if (dcyc[i] != 0 && dcyc[i] <= fin) begin
                e.dmask[i] = 1'b1;
                e.fmask[i] = !pbit[i];
`ifdef MP_MON_TSTAMP_EN
                e.stamp[i] = CW'(dcyc[i]);
`endif
                if (drop[i] > dcyc[i] && drop[i] <= fin) e.perr = 1'b1;
            end
        end
        e.pass = e.done && (e.fmask == '0);
        return e;
    endfunction

    task automatic drive_cycle(input int k);
        bus.start = ($urandom_range(0, 7) == 0);
        for (int i = 0; i < N; i++) begin
            bus.core_done[i] = (dcyc[i] != 0) && (k >= dcyc[i]) && (k != drop[i]);
            bus.core_pass[i] = (k == dcyc[i]) ? pbit[i] : 1'($urandom);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_run_done"}, bus.run_done, 0);
        chk({tag, "_run_pass"}, bus.run_pass, 0);
        chk({tag, "_timeout"}, bus.run_timeout, 0);
        chk({tag, "_done_mask"}, bus.done_mask, 0);
        chk({tag, "_fail_mask"}, bus.fail_mask, 0);
        chk({tag, "_total"}, bus.total_cycles, 0);
        chk({tag, "_proto_err"}, bus.proto_err, 0);
        for (int j = 0; j < N; j++) begin
            bus.rd_idx = IW'(j);
            #1;
            chk($sformatf("%s_stamp%0d", tag, j), bus.rd_tstamp, 0);
        end
    endtask

    task automatic do_run();
        exp_t e;
        int   len;
        e   = model();
        len = int'(e.total);
        ack = 1'b0;
        q.push_back(e);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("run_busy", bus.busy, 1);
                chk("run_clr_total", bus.total_cycles, 0);
                chk("run_clr_perr", bus.proto_err, 0);
                chk("run_clr_mask", bus.done_mask, 0);
                chk("run_clr_verdict", {bus.run_done, bus.run_timeout}, 0);
            end
            drive_cycle(k);
            @(posedge clk);
        end
        @(negedge clk);
        bus.start     = 1'b0;
        bus.core_done = N'($urandom);
        bus.core_pass = N'($urandom);
        for (int w = 0; w < 20 && !ack; w++) @(negedge clk);
        if (!ack) chk("verdict_wait", 0, 1);
        bus.core_done = '0;
    endtask

    task automatic set_run(input int d0, input int d1, input int d2,
                           input bit p0, input bit p1, input bit p2);
        dcyc = '{d0, d1, d2};
        pbit = '{p0, p1, p2};
        drop = '{0, 0, 0};
    endtask

    // monitor: one verdict per completed run, read when busy falls
    initial begin
        exp_t e;
        bit   pb;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (pb && !bus.busy && !aborting) begin
                if (q.size() == 0) begin
                    chk("unexpected_end", 0, 1);
                end else begin
                    e = q.pop_front();
                    chk("run_done", bus.run_done, e.done);
                    chk("run_pass", bus.run_pass, e.pass);
                    chk("run_timeout", bus.run_timeout, e.tmo);
                    chk("done_mask", bus.done_mask, e.dmask);
                    chk("fail_mask", bus.fail_mask, e.fmask);
                    chk("total_cycles", bus.total_cycles, e.total);
                    chk("proto_err", bus.proto_err, e.perr);
                    for (int j = 0; j < (1 << IW); j++) begin
                        bus.rd_idx = IW'(j);
                        #1;
                        chk($sformatf("stamp%0d", j), bus.rd_tstamp,
                            (j < N) ? e.stamp[j] : 0);
                    end
                    ack = 1'b1;
                end
            end
            pb = bus.busy;
        end
    end

    initial begin
        bus.start     = 1'b0;
        bus.core_done = '0;
        bus.core_pass = '0;
        bus.rd_idx    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_zero("reset");

        set_run(5, 9, 12, 1, 1, 1);
        do_run();

        set_run($urandom_range(1, 20), $urandom_range(1, 20), 20, 1, 0, 1);
        do_run();

        set_run($urandom_range(1, 100), $urandom_range(1, 100), 0,
                1'($urandom), 1'($urandom), 1'($urandom));
        do_run();

        set_run($urandom_range(1, 399), $urandom_range(1, 399), 400, 1, 1, 1);
        do_run();

        // abort a run by reset at cycle 50
        set_run(10, 20, 0, 1, 0, 1);
        aborting = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k < 50; k++) begin
            @(negedge clk);
            drive_cycle(k);
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        bus.core_done = '0;
        chk_zero("mid_rst");
        aborting = 1'b0;

        set_run(3, 4, 6, 1, 1, 0);
        do_run();

        set_run(3, 6, 7, 1'($urandom), 1, 1);
        drop = '{4, 0, 0};
        do_run();

        set_run(2, 2, 8, 1, 1, 1);
        do_run();

        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < N; i++) begin
                dcyc[i] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 440);
                pbit[i] = 1'($urandom);
                drop[i] = 0;
                if (dcyc[i] != 0 && $urandom_range(0, 3) == 0)
                    drop[i] = dcyc[i] + $urandom_range(1, 30);
            end
            do_run();
        end

        if (q.size() != 0) chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
